// File: rtl/uvma_obi_chkr_pkg.sv
// rtl/uvma_obi_chkr_pkg.sv - shared error codes and constants for the OBI protocol checker
package uvma_obi_chkr_pkg;

  localparam int UVMA_OBI_CHKR_N_ERR = 6;

  // Values double as bit indices into err_sticky/err_pulse
  typedef enum logic [2:0] {
    UVMA_OBI_CHKR_A_STABLE    = 3'd0,
    UVMA_OBI_CHKR_R_STABLE    = 3'd1,
    UVMA_OBI_CHKR_OVERFLOW    = 3'd2,
    UVMA_OBI_CHKR_UNDERFLOW   = 3'd3,
    UVMA_OBI_CHKR_TIMEOUT     = 3'd4,
    UVMA_OBI_CHKR_ID_MISMATCH = 3'd5
  } uvma_obi_chkr_err_enum;

endpackage

// File: rtl/uvma_obi_chkr_id_fifo.sv
// rtl/uvma_obi_chkr_id_fifo.sv - in-order FIFO of A-channel IDs awaiting their response
module uvma_obi_chkr_id_fifo #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic [ID_W-1:0] data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [ID_W-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // A pop frees the head slot in the same cycle, so push while full is fine then
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/uvma_obi_prot_chkr.sv
// rtl/uvma_obi_prot_chkr.sv - passive OBI A/R protocol checker with sticky/pulse flags and error count
// Optional in-order ID matching is enabled by defining UVMA_OBI_CHKR_ID_CHECK_EN.
module uvma_obi_prot_chkr
  import uvma_obi_chkr_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int CNT_W           = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req,
  input  logic                                 gnt,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic                                 we,
  input  logic [DATA_W/8-1:0]                  be,
  input  logic [DATA_W-1:0]                    wdata,
  input  logic [ID_W-1:0]                      aid,
  input  logic                                 rvalid,
  input  logic                                 rready,
  input  logic [DATA_W-1:0]                    rdata,
  input  logic                                 err,
  input  logic [ID_W-1:0]                      rid,
  input  logic                                 clr,
  output logic [UVMA_OBI_CHKR_N_ERR-1:0]       err_sticky,
  output logic [UVMA_OBI_CHKR_N_ERR-1:0]       err_pulse,
  output logic [CNT_W-1:0]                     err_count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0;
  localparam int TO_M1  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic                          a_hs, r_hs;
  logic                          a_wait_q;
  logic [ADDR_W-1:0]             addr_q;
  logic                          we_q;
  logic [DATA_W/8-1:0]           be_q;
  logic [DATA_W-1:0]             wdata_q;
  logic [ID_W-1:0]               aid_q;
  logic                          r_wait_q;
  logic [DATA_W-1:0]             rdata_q;
  logic                          rerr_q;
  logic [ID_W-1:0]               rid_q;

  logic [OW-1:0]                 cur_q, cur_d;
  logic [WD_W-1:0]               wd_q, wd_d;
  logic                          wd_inc;
  logic                          ovf, unf, tmo, id_mis;
  logic                          a_unstable, r_unstable;
  logic [UVMA_OBI_CHKR_N_ERR-1:0] viol;
  logic                          any_viol;
  logic [UVMA_OBI_CHKR_N_ERR-1:0] sticky_q, sticky_d;
  logic [UVMA_OBI_CHKR_N_ERR-1:0] pulse_q;
  logic [CNT_W-1:0]              count_q, count_d;

  assign a_hs = req & gnt;
  assign r_hs = rvalid & rready;

  assign a_unstable = a_wait_q & (~req | (addr != addr_q) | (we != we_q) | (be != be_q) |
                                  (aid != aid_q) | (we & (wdata != wdata_q)));
  assign r_unstable = r_wait_q & (~rvalid | (rdata != rdata_q) | (err != rerr_q) | (rid != rid_q));

  assign unf = r_hs & (cur_q == '0);
  assign ovf = a_hs & ~r_hs & (cur_q == OW'(MAX_OUTSTANDING));

  // A response can never share the grant cycle, so an underflow leaves only the new grant in flight
  always_comb begin
    if (unf)      cur_d = OW'(a_hs);
    else if (ovf) cur_d = OW'(MAX_OUTSTANDING);
    else          cur_d = cur_q + OW'(a_hs) - OW'(r_hs);
  end

  assign wd_inc = (TIMEOUT_CYCLES != 0) && (cur_q != '0) && !r_hs && (wd_q != WD_W'(TO_LIM));
  assign tmo    = wd_inc && (wd_q == WD_W'(TO_M1));

  always_comb begin
    if (r_hs || (cur_q == '0)) wd_d = '0;
    else if (wd_inc)           wd_d = wd_q + WD_W'(1);
    else                       wd_d = wd_q;
  end

`ifdef UVMA_OBI_CHKR_ID_CHECK_EN
  logic [ID_W-1:0] id_head;
  logic            id_empty;
  logic            id_full_unused;
  logic            id_pop;

  assign id_pop = r_hs & ~unf;
  assign id_mis = id_pop & ~id_empty & (rid != id_head);

  uvma_obi_chkr_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (a_hs & ~ovf),
    .data_i  (aid),
    .pop_i   (id_pop),
    .full_o  (id_full_unused),
    .empty_o (id_empty),
    .head_o  (id_head)
  );
`else
  assign id_mis = 1'b0;
`endif

  always_comb begin
    viol                            = '0;
    viol[UVMA_OBI_CHKR_A_STABLE]    = a_unstable;
    viol[UVMA_OBI_CHKR_R_STABLE]    = r_unstable;
    viol[UVMA_OBI_CHKR_OVERFLOW]    = ovf;
    viol[UVMA_OBI_CHKR_UNDERFLOW]   = unf;
    viol[UVMA_OBI_CHKR_TIMEOUT]     = tmo;
    viol[UVMA_OBI_CHKR_ID_MISMATCH] = id_mis;
  end

  assign any_viol = |viol;

  // A violation coinciding with clr survives the clear
  always_comb begin
    sticky_d = clr ? viol : (sticky_q | viol);
    if (clr)                                   count_d = any_viol ? CNT_W'(1) : '0;
    else if (any_viol && (count_q != '1))      count_d = count_q + CNT_W'(1);
    else                                       count_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_wait_q <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      aid_q    <= '0;
      r_wait_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rid_q    <= '0;
      cur_q    <= '0;
      wd_q     <= '0;
      sticky_q <= '0;
      pulse_q  <= '0;
      count_q  <= '0;
    end else begin
      a_wait_q <= req & ~gnt;
      addr_q   <= addr;
      we_q     <= we;
      be_q     <= be;
      wdata_q  <= wdata;
      aid_q    <= aid;
      r_wait_q <= rvalid & ~rready;
      rdata_q  <= rdata;
      rerr_q   <= err;
      rid_q    <= rid;
      cur_q    <= cur_d;
      wd_q     <= wd_d;
      sticky_q <= sticky_d;
      pulse_q  <= viol;
      count_q  <= count_d;
    end
  end

  assign err_sticky  = sticky_q;
  assign err_pulse   = pulse_q;
  assign err_count   = count_q;
  assign outstanding = cur_q;

endmodule
